ext_bus_arbiter: RTL and testbench

Two-master arbiter for the SoC external SBA bus, sitting between the masters and the address decoder that fans out to the cfg, LED, UART and SPI devices. Master 0 is the CPU port of `soc`; master 1 is a future DMA or debug master. The block grants the bus round-robin and holds the grant for the whole transaction. A timeout watchdog terminates any transaction that no device acknowledges, so an unmapped address cannot hang a master.

---
 rtl/ext_bus_arbiter_pkg.sv | 19 +
 rtl/ext_bus_arbiter_if.sv | 51 +++++
 rtl/ext_bus_timeout.sv | 34 +++
 rtl/ext_bus_arbiter.sv | 104 ++++++++++
 tb/tb_ext_bus_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ext_bus_arbiter_pkg.sv
// ext_bus_arbiter_pkg
// Shared definitions for the external SBA bus arbiter, its interface and the
// address decoder in soc top: bus widths, FSM state encoding and the default
// timeout parameters.
package ext_bus_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int WE_W   = 4;

  localparam int                TIMEOUT_CYCLES_DEF = 255;
  localparam logic [DATA_W-1:0] TIMEOUT_DATA_DEF   = 32'hDEAD_BEEF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/ext_bus_arbiter_if.sv
// ext_bus_arbiter_if
// Bundles the two master ports and the decoder-side port of the SBA bus.
//   master side : i_mX_addr/stb/we/dat_w driven by masters, o_mX_ack/dat_r back
//   slave side  : o_s_addr/stb/we/dat_w to the decoder, i_s_ack/dat_r back
//   status      : o_timeout pulse, o_busy level
// Handshake: a master raises i_mX_stb with stable addr/we/dat_w and holds it
// until o_mX_ack is seen (one-cycle strobe); lowering stb earlier aborts the
// request. Towards the decoder, o_s_stb is the request and i_s_ack completes it
// in the same cycle; i_s_ack may be combinational from o_s_stb.
interface ext_bus_arbiter_if;
  import ext_bus_arbiter_pkg::*;

  logic [ADDR_W-1:0] i_m0_addr,  i_m1_addr;
  logic              i_m0_stb,   i_m1_stb;
  logic [WE_W-1:0]   i_m0_we,    i_m1_we;
  logic [DATA_W-1:0] i_m0_dat_w, i_m1_dat_w;
  logic              o_m0_ack,   o_m1_ack;
  logic [DATA_W-1:0] o_m0_dat_r, o_m1_dat_r;

  logic [ADDR_W-1:0] o_s_addr;
  logic              o_s_stb;
  logic [WE_W-1:0]   o_s_we;
  logic [DATA_W-1:0] o_s_dat_w;
  logic              i_s_ack;
  logic [DATA_W-1:0] i_s_dat_r;

  logic              o_timeout;
  logic              o_busy;

  // Arbiter view.
  modport arb (
    input  i_m0_addr, i_m1_addr, i_m0_stb, i_m1_stb, i_m0_we, i_m1_we,
           i_m0_dat_w, i_m1_dat_w, i_s_ack, i_s_dat_r,
    output o_m0_ack, o_m1_ack, o_m0_dat_r, o_m1_dat_r,
           o_s_addr, o_s_stb, o_s_we, o_s_dat_w, o_timeout, o_busy
  );

  // Requesting masters.
  modport master (
    output i_m0_addr, i_m1_addr, i_m0_stb, i_m1_stb, i_m0_we, i_m1_we,
           i_m0_dat_w, i_m1_dat_w,
    input  o_m0_ack, o_m1_ack, o_m0_dat_r, o_m1_dat_r, o_timeout, o_busy
  );

  // Address decoder / devices.
  modport slave (
    input  o_s_addr, o_s_stb, o_s_we, o_s_dat_w,
    output i_s_ack, i_s_dat_r
  );

endinterface

// File: rtl/ext_bus_timeout.sv
// ext_bus_timeout
// Transaction watchdog counter.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : clear the count (has priority over i_en)
//   i_en           : count one stalled BUSY cycle
//   o_expired      : count has reached TIMEOUT_CYCLES-1
module ext_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q;

  // Saturates at the limit so a late enable can never wrap the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_en && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign o_expired = (cnt_q == LIMIT);

endmodule

// File: rtl/ext_bus_arbiter.sv
// ext_bus_arbiter
// Two-master round-robin arbiter for the external SBA bus. The grant is held
// for the whole transaction; a watchdog ends any transaction no device acks.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus            : master ports, decoder port and status (ext_bus_arbiter_if)
//   o_state        : current FSM state, for debug and checkers
module ext_bus_arbiter
  import ext_bus_arbiter_pkg::*;
#(
  parameter int                TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  ext_bus_arbiter_if.arb     bus,
  output state_e             o_state
);

  state_e state_q;
  logic   owner_q;   // master holding the current grant
  logic   last_q;    // master served by the last completed transaction

  logic              busy;
  logic              own_stb;
  logic [ADDR_W-1:0] own_addr;
  logic [WE_W-1:0]   own_we;
  logic [DATA_W-1:0] own_dat_w;
  logic              expired;
  logic              done_ack;
  logic              done_tmo;
  logic              done;
  logic [DATA_W-1:0] rsp_dat;

  assign busy = (state_q == ST_BUSY);

  always_comb begin
    own_stb   = owner_q ? bus.i_m1_stb   : bus.i_m0_stb;
    own_addr  = owner_q ? bus.i_m1_addr  : bus.i_m0_addr;
    own_we    = owner_q ? bus.i_m1_we    : bus.i_m0_we;
    own_dat_w = owner_q ? bus.i_m1_dat_w : bus.i_m0_dat_w;
  end

  ext_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (!busy),
    .i_en     (busy),
    .o_expired(expired)
  );

  // A device ack beats an expiry in the same cycle. An owner that has dropped
  // stb has aborted, so neither completion applies.
  assign done_ack = busy && own_stb && bus.i_s_ack;
  assign done_tmo = busy && own_stb && !bus.i_s_ack && expired;
  assign done     = done_ack || done_tmo;
  assign rsp_dat  = done_ack ? bus.i_s_dat_r : TIMEOUT_DATA;

  always_comb begin
    bus.o_s_addr   = busy ? own_addr  : '0;
    bus.o_s_we     = busy ? own_we    : '0;
    bus.o_s_dat_w  = busy ? own_dat_w : '0;
    // The request is withdrawn in the expiry cycle so the decoder sees the
    // transaction end together with the forced ack.
    bus.o_s_stb    = busy && own_stb && !expired;
    bus.o_m0_ack   = done && !owner_q;
    bus.o_m1_ack   = done &&  owner_q;
    bus.o_m0_dat_r = (done && !owner_q) ? rsp_dat : '0;
    bus.o_m1_dat_r = (done &&  owner_q) ? rsp_dat : '0;
    bus.o_timeout  = done_tmo;
    bus.o_busy     = busy;
  end

  assign o_state = state_q;

  // last_q resets to 1 so master 0 wins the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_m0_stb || bus.i_m1_stb) begin
            owner_q <= (bus.i_m0_stb && bus.i_m1_stb) ? !last_q : bus.i_m1_stb;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!own_stb) begin
            state_q <= ST_IDLE;
          end else if (done) begin
            last_q  <= owner_q;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// tb_ext_bus_arbiter
// Directed scenarios with literal expectations, then randomized traffic from
// two masters and a device with random wait states, stalls and stray acks.
// A transaction-level reference model checks every output on every cycle.
module tb_ext_bus_arbiter;
  import ext_bus_arbiter_pkg::*;

  localparam int          T    = 8;
  localparam logic [31:0] TDAT = 32'hDEAD_BEEF;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ext_bus_arbiter_if bus();
  state_e dbg_state;

  ext_bus_arbiter #(
    .TIMEOUT_CYCLES(T),
    .TIMEOUT_DATA  (TDAT)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus),
    .o_state(dbg_state)
  );

  // ---------------- device model ----------------
  int          dev_wait = 0;     // wait cycles before ack
  logic        dev_on   = 1'b1;  // 0 = unmapped address, never acks
  logic        dev_raw  = 1'b0;  // stray ack regardless of o_s_stb
  logic [31:0] dev_dat  = '0;
  int          dev_cnt  = 0;     // consecutive stalled stb cycles

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dev_cnt <= 0;
    else        dev_cnt <= (bus.o_s_stb && !bus.i_s_ack) ? dev_cnt + 1 : 0;
  end

  assign bus.i_s_ack   = dev_raw | (bus.o_s_stb & dev_on & (dev_cnt >= dev_wait));
  assign bus.i_s_dat_r = dev_dat;

  // ---------------- check bookkeeping ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_m(input int m, input logic stb, input logic [15:0] addr,
                       input logic [3:0] we, input logic [31:0] dat);
    if (m == 0) begin
      bus.i_m0_stb = stb; bus.i_m0_addr = addr; bus.i_m0_we = we; bus.i_m0_dat_w = dat;
    end else begin
      bus.i_m1_stb = stb; bus.i_m1_addr = addr; bus.i_m1_we = we; bus.i_m1_dat_w = dat;
    end
  endtask

  task automatic rand_req(input int m);
    set_m(m, 1'b1, 16'($urandom_range(0, 16'hFFFF)), 4'($urandom_range(0, 15)), $urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model + compare ----------------
  // Transaction view: a grant is taken in an idle cycle, a transaction then
  // lives for some BUSY cycles (age counts from 0) and ends by device ack,
  // by reaching age T-1, or by the owner withdrawing its request.
  logic chk_en    = 1'b0;
  logic seen_ack0 = 1'b0;
  logic seen_ack1 = 1'b0;
  logic mdl_busy  = 1'b0;
  logic mdl_owner = 1'b0;
  logic mdl_last  = 1'b1;
  int   mdl_age   = 0;

  always @(negedge clk) begin
    logic [15:0] ea;
    logic [3:0]  ew;
    logic [31:0] ed, er;
    logic es, eb, et, ea0, ea1, ostb, dack, fin;
    seen_ack0 = bus.o_m0_ack;
    seen_ack1 = bus.o_m1_ack;
    ea = '0; ew = '0; ed = '0; er = '0;
    es = 1'b0; eb = 1'b0; et = 1'b0; ea0 = 1'b0; ea1 = 1'b0; fin = 1'b0;
    if (chk_en) begin
      if (!rst_n) begin
        mdl_busy = 1'b0; mdl_owner = 1'b0; mdl_last = 1'b1; mdl_age = 0;
      end else if (mdl_busy) begin
        eb   = 1'b1;
        ostb = mdl_owner ? bus.i_m1_stb   : bus.i_m0_stb;
        ea   = mdl_owner ? bus.i_m1_addr  : bus.i_m0_addr;
        ew   = mdl_owner ? bus.i_m1_we    : bus.i_m0_we;
        ed   = mdl_owner ? bus.i_m1_dat_w : bus.i_m0_dat_w;
        if (!ostb) begin
          mdl_busy = 1'b0;
        end else begin
          es   = (mdl_age != T - 1);
          dack = dev_raw || (es && dev_on && (dev_cnt >= dev_wait));
          if (dack || (mdl_age == T - 1)) begin
            fin      = 1'b1;
            er       = dack ? dev_dat : TDAT;
            et       = !dack;
            mdl_last = mdl_owner;
            mdl_busy = 1'b0;
          end else begin
            mdl_age++;
          end
        end
        ea0 = fin && !mdl_owner;
        ea1 = fin &&  mdl_owner;
      end else if (bus.i_m0_stb || bus.i_m1_stb) begin
        mdl_owner = (bus.i_m0_stb && bus.i_m1_stb) ? !mdl_last : bus.i_m1_stb;
        mdl_busy  = 1'b1;
        mdl_age   = 0;
      end
      chk1 ("s_stb",    bus.o_s_stb,    es);
      chk32("s_addr",   32'(bus.o_s_addr), 32'(ea));
      chk32("s_we",     32'(bus.o_s_we),   32'(ew));
      chk32("s_dat_w",  bus.o_s_dat_w,  ed);
      chk1 ("m0_ack",   bus.o_m0_ack,   ea0);
      chk1 ("m1_ack",   bus.o_m1_ack,   ea1);
      chk32("m0_dat_r", bus.o_m0_dat_r, ea0 ? er : 32'h0);
      chk32("m1_dat_r", bus.o_m1_dat_r, ea1 ? er : 32'h0);
      chk1 ("timeout",  bus.o_timeout,  et);
      chk1 ("busy",     bus.o_busy,     eb);
      chk1 ("state",    dbg_state == ST_BUSY, eb);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    set_m(0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, '0, '0, '0);
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    step(); step();
    chk1 ("rst_s_stb", bus.o_s_stb,  1'b0);
    chk1 ("rst_busy",  bus.o_busy,   1'b0);
    chk1 ("rst_m0ack", bus.o_m0_ack, 1'b0);
    rst_n = 1'b1;
    step();

    // m0 read, zero-wait device
    dev_wait = 0; dev_on = 1'b1; dev_dat = 32'h0000_00A5;
    set_m(0, 1'b1, 16'h1000, 4'h0, 32'h0);
    @(negedge clk);
    chk1("a_idle_busy", bus.o_busy, 1'b0);
    step();
    @(negedge clk);
    chk1 ("a_m0_ack",   bus.o_m0_ack, 1'b1);
    chk32("a_m0_dat",   bus.o_m0_dat_r, 32'h0000_00A5);
    chk1 ("a_m1_ack",   bus.o_m1_ack, 1'b0);
    chk32("a_addr",     32'(bus.o_s_addr), 32'h1000);
    step();
    set_m(0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk1("a_ack_once", bus.o_m0_ack, 1'b0);
    chk1("a_idle",     bus.o_busy,   1'b0);
    step();

    // reset in the 2nd BUSY cycle of a stalled m1 write
    dev_on = 1'b0;
    set_m(1, 1'b1, 16'h2000, 4'hF, 32'h1234_5678);
    step();
    @(negedge clk);
    chk1("e_busy1", bus.o_busy, 1'b1);
    step();
    rst_n = 1'b0;
    #1;
    chk1 ("e_stb",   bus.o_s_stb,  1'b0);
    chk1 ("e_busy",  bus.o_busy,   1'b0);
    chk1 ("e_m1ack", bus.o_m1_ack, 1'b0);
    chk32("e_addr",  32'(bus.o_s_addr), 32'h0);
    set_m(0, 1'b1, 16'h1000, 4'h0, 32'h0);
    step(); step();
    rst_n = 1'b1; dev_on = 1'b1; dev_wait = 0; dev_dat = 32'h0000_0077;

    // both held: m0 first, then strict alternation
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk1("b_m0_ack", bus.o_m0_ack, (k % 4) == 2);
      chk1("b_m1_ack", bus.o_m1_ack, (k % 4) == 0);
      if ((k % 2) == 0)
        chk32("b_addr", 32'(bus.o_s_addr), ((k % 4) == 2) ? 32'h1000 : 32'h2000);
      step();
    end
    set_m(0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, '0, '0, '0);
    step();

    // m1 write, three wait states
    dev_wait = 3;
    set_m(1, 1'b1, 16'h3004, 4'b0001, 32'h55);
    for (int b = 1; b <= 4; b++) begin
      step();
      @(negedge clk);
      chk1 ("c_stb",   bus.o_s_stb, 1'b1);
      chk32("c_addr",  32'(bus.o_s_addr), 32'h3004);
      chk32("c_we",    32'(bus.o_s_we), 32'h1);
      chk32("c_dat",   bus.o_s_dat_w, 32'h55);
      chk1 ("c_m1ack", bus.o_m1_ack, b == 4);
      chk1 ("c_m0ack", bus.o_m0_ack, 1'b0);
    end
    step();
    set_m(1, 1'b0, '0, '0, '0);
    step();

    // m0 to an unmapped address: timeout in the 8th BUSY cycle
    dev_on = 1'b0; dev_wait = 0;
    set_m(0, 1'b1, 16'h8000, 4'h0, 32'h0);
    for (int b = 1; b <= T; b++) begin
      step();
      @(negedge clk);
      chk1("d_m0ack", bus.o_m0_ack,  b == T);
      chk1("d_tmo",   bus.o_timeout, b == T);
      chk1("d_stb",   bus.o_s_stb,   b != T);
      if (b == T) chk32("d_dat", bus.o_m0_dat_r, 32'hDEAD_BEEF);
    end
    step();
    set_m(0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk1("d_idle", bus.o_busy, 1'b0);
    step();

    // m1 granted on a tie (last was m0), aborts; waiting m0 is served next
    set_m(0, 1'b1, 16'h0100, 4'h0, 32'h0);
    set_m(1, 1'b1, 16'h0200, 4'h0, 32'h0);
    step();
    @(negedge clk);
    chk32("f_owner1", 32'(bus.o_s_addr), 32'h0200);
    step();
    set_m(1, 1'b0, '0, '0, '0);
    dev_on = 1'b1;
    @(negedge clk);
    chk1("f_stb_drop", bus.o_s_stb,  1'b0);
    chk1("f_no_ack",   bus.o_m1_ack, 1'b0);
    step();
    @(negedge clk);
    chk1("f_idle", bus.o_busy, 1'b0);
    step();
    @(negedge clk);
    chk32("f_owner0", 32'(bus.o_s_addr), 32'h0100);
    chk1 ("f_m0ack",  bus.o_m0_ack, 1'b1);
    step();
    set_m(0, 1'b0, '0, '0, '0);
    step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < 2; m++) begin
        logic cur, ack;
        cur = (m == 0) ? bus.i_m0_stb : bus.i_m1_stb;
        ack = (m == 0) ? seen_ack0 : seen_ack1;
        if (cur && ack) begin
          if ($urandom_range(0, 1) == 1) rand_req(m);
          else set_m(m, 1'b0, '0, '0, '0);
        end else if (cur) begin
          if ($urandom_range(0, 29) == 0) set_m(m, 1'b0, '0, '0, '0);
        end else if ($urandom_range(0, 2) == 0) begin
          rand_req(m);
        end
      end
      dev_wait = $urandom_range(0, 3);
      dev_raw  = ($urandom_range(0, 19) == 0);
      dev_dat  = $urandom;
      if ($urandom_range(0, 15) == 0) dev_on = !dev_on;
      step();
    end

    set_m(0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, '0, '0, '0);
    dev_raw = 1'b0;
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
